// File: rtl/ospi_host_ctrl_pkg.sv
// Shared OSPI frame definitions: opcodes, phase lengths, FSM states and the header byte mux.
// Imported by the host controller and by the target RAM so both agree on frame layout.
package ospi_host_ctrl_pkg;

  localparam logic [3:0] OP_WRITE       = 4'hA;
  localparam logic [3:0] OP_READ        = 4'h2;
  localparam int         HDR_LEN        = 8;
  localparam int         DMY_LEN        = 2;
  localparam int         RD_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DUMMY,
    WDATA,
    RDATA,
    TAIL
  } state_e;

  function automatic logic [7:0] hdr_byte(input logic        wr,
                                          input logic [3:0]  size,
                                          input logic [23:0] len,
                                          input logic [31:0] addr,
                                          input logic [2:0]  idx);
    case (idx)
      3'd0:    return {(wr ? OP_WRITE : OP_READ), size};
      3'd1:    return len[23:16];
      3'd2:    return len[15:8];
      3'd3:    return len[7:0];
      3'd4:    return addr[31:24];
      3'd5:    return addr[23:16];
      3'd6:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ospi_host_ctrl_if.sv
// Command, write/read stream and OSPI pad-side signals of the host controller.
// master = the controller's own view, slave = the surrounding logic and target.
interface ospi_host_ctrl_if;
  import ospi_host_ctrl_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_size;
  logic [23:0] cmd_len;
  logic [31:0] cmd_addr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ospi_ncs;
  logic [7:0]  ospi_dq_o;
  logic        ospi_dq_oe;
  logic [7:0]  ospi_dq_i;
  logic        busy;
  logic        done;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_len, cmd_addr, tx_data, tx_valid, ospi_dq_i,
    output cmd_ready, tx_ready, rx_data, rx_valid, ospi_ncs, ospi_dq_o, ospi_dq_oe, busy, done
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_len, cmd_addr, tx_data, tx_valid, ospi_dq_i,
    input  cmd_ready, tx_ready, rx_data, rx_valid, ospi_ncs, ospi_dq_o, ospi_dq_oe, busy, done
  );

endinterface

// File: rtl/ospi_host_ctrl_rx_capture.sv
// Delays the read-slot marker by RD_LAT slots, then samples the bus into rx_data
// with a one-cycle rx_valid strobe (no backpressure).
module ospi_rx_capture #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_slot,
  input  logic [7:0] dq_i,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  logic       sample_en;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  generate
    if (RD_LAT == 0) begin : g_direct
      assign sample_en = rd_slot;
    end else begin : g_pipe
      logic [RD_LAT-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = (pipe_q << 1) | RD_LAT'(rd_slot);
      end

      always_ff @(posedge clk) begin
        if (!reset_n) pipe_q <= '0;
        else          pipe_q <= pipe_d;
      end

      assign sample_en = pipe_q[RD_LAT-1];
    end
  endgenerate

  always_comb begin
    rx_valid_d = sample_en;
    rx_data_d  = sample_en ? dq_i : rx_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: rtl/ospi_host_ctrl.sv
// Octal-SPI SDR x8 host: header, dummy (read), data and one tail slot per command.
// state_q names the phase on the bus now; every bus output is registered from the next phase.
module ospi_host_ctrl
  import ospi_host_ctrl_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input logic              clk,
  input logic              reset_n,
  ospi_host_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [2:0]  slot_cnt_q, slot_cnt_d;
  logic [23:0] data_cnt_q, data_cnt_d;
  logic        cmd_write_q, cmd_write_d;
  logic [3:0]  cmd_size_q, cmd_size_d;
  logic [23:0] cmd_len_q, cmd_len_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic        ncs_q, ncs_d;
  logic        oe_q, oe_d;
  logic [7:0]  dq_o_q, dq_o_d;
  logic        done_q, done_d;
  logic        accept;
  logic        wr_take;
  logic        rd_slot;

  assign accept = bus.cmd_valid && (state_q == IDLE);

  // A write byte is taken in the cycle before the slot that drives it; no byte means a pause slot.
  always_comb begin
    wr_take = 1'b0;
    if (reset_n && bus.tx_valid) begin
      if (state_q == HDR && slot_cnt_q == 3'(HDR_LEN - 1) && cmd_write_q && cmd_len_q != 24'd0)
        wr_take = 1'b1;
      if (state_q == WDATA && data_cnt_q != cmd_len_q)
        wr_take = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    data_cnt_d  = wr_take ? data_cnt_q + 24'd1 : data_cnt_q;
    cmd_write_d = cmd_write_q;
    cmd_size_d  = cmd_size_q;
    cmd_len_d   = cmd_len_q;
    cmd_addr_d  = cmd_addr_q;
    case (state_q)
      IDLE: if (accept) begin
        cmd_write_d = bus.cmd_write;
        cmd_size_d  = bus.cmd_size;
        cmd_len_d   = bus.cmd_len;
        cmd_addr_d  = bus.cmd_addr;
        slot_cnt_d  = 3'd0;
        data_cnt_d  = 24'd0;
        state_d     = HDR;
      end
      HDR: if (slot_cnt_q == 3'(HDR_LEN - 1)) begin
        slot_cnt_d = 3'd0;
        if (!cmd_write_q)              state_d = DUMMY;
        else if (cmd_len_q == 24'd0)   state_d = TAIL;
        else                           state_d = WDATA;
      end else begin
        slot_cnt_d = slot_cnt_q + 3'd1;
      end
      DUMMY: if (slot_cnt_q == 3'(DMY_LEN - 1)) begin
        data_cnt_d = 24'd0;
        state_d    = (cmd_len_q == 24'd0) ? TAIL : RDATA;
      end else begin
        slot_cnt_d = slot_cnt_q + 3'd1;
      end
      WDATA: if (data_cnt_q == cmd_len_q) state_d = TAIL;
      RDATA: if (data_cnt_q == cmd_len_q - 24'd1) state_d = TAIL;
             else data_cnt_d = data_cnt_q + 24'd1;
      TAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ncs_d  = 1'b1;
    oe_d   = 1'b0;
    dq_o_d = 8'h00;
    done_d = (state_q == TAIL);
    case (state_d)
      HDR: begin
        ncs_d  = 1'b0;
        oe_d   = 1'b1;
        dq_o_d = hdr_byte(cmd_write_d, cmd_size_d, cmd_len_d, cmd_addr_d, slot_cnt_d);
      end
      DUMMY, RDATA, TAIL: ncs_d = 1'b0;
      WDATA: if (wr_take) begin
        ncs_d  = 1'b0;
        oe_d   = 1'b1;
        dq_o_d = bus.tx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      slot_cnt_q  <= 3'd0;
      data_cnt_q  <= 24'd0;
      cmd_write_q <= 1'b0;
      cmd_size_q  <= 4'd0;
      cmd_len_q   <= 24'd0;
      cmd_addr_q  <= 32'd0;
      ncs_q       <= 1'b1;
      oe_q        <= 1'b0;
      dq_o_q      <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      data_cnt_q  <= data_cnt_d;
      cmd_write_q <= cmd_write_d;
      cmd_size_q  <= cmd_size_d;
      cmd_len_q   <= cmd_len_d;
      cmd_addr_q  <= cmd_addr_d;
      ncs_q       <= ncs_d;
      oe_q        <= oe_d;
      dq_o_q      <= dq_o_d;
      done_q      <= done_d;
    end
  end

  assign rd_slot = (state_q == RDATA);

  ospi_rx_capture #(.RD_LAT(RD_LAT)) u_rx_capture (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_slot  (rd_slot),
    .dq_i     (bus.ospi_dq_i),
    .rx_data  (bus.rx_data),
    .rx_valid (bus.rx_valid)
  );

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.tx_ready   = wr_take;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.ospi_ncs   = ncs_q;
  assign bus.ospi_dq_oe = oe_q;
  assign bus.ospi_dq_o  = dq_o_q;

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Directed bench for ospi_host_ctrl with a behavioural OSPI target RAM (read latency 1 slot).
module tb_ospi_host_ctrl;
  import ospi_host_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ospi_host_ctrl_if bus ();
  ospi_host_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Bus monitor: per-cycle ncs trace, ncs-low slots as {oe,dq}, received bytes with cycle stamps.
  int         cyc = 0;
  logic       ncs_tr [$];
  logic [8:0] slot_q [$];
  logic [7:0] rx_q   [$];
  int         rx_cyc [$];
  always @(negedge clk) begin
    cyc++;
    ncs_tr.push_back(bus.ospi_ncs);
    if (bus.ospi_ncs === 1'b0) slot_q.push_back({bus.ospi_dq_oe, bus.ospi_dq_o});
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rx_cyc.push_back(cyc);
    end
  end

  // Target RAM model: parses the header, stores write data, returns read byte k during slot k+1.
  logic [7:0] wmem [0:255];
  logic [7:0] rmem [0:255];
  logic [7:0] t_hdr [0:7];
  int         t_cnt, t_len, t_idx;
  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = 8'(i);
    rmem[8'h10] = 8'h11; rmem[8'h11] = 8'h22; rmem[8'h12] = 8'h33;
    rmem[8'h50] = 8'h99; rmem[8'h51] = 8'h88; rmem[8'h52] = 8'h77;
  end
  always @(posedge clk) begin
    if (!reset_n) begin
      t_cnt = 0;
      bus.ospi_dq_i <= 8'h00;
    end else if (bus.ospi_ncs === 1'b0) begin
      if (t_cnt < 8) begin
        t_hdr[t_cnt] = bus.ospi_dq_o;
        t_cnt++;
      end else begin
        t_len = int'({t_hdr[1], t_hdr[2], t_hdr[3]});
        if (t_hdr[0][7:4] == OP_WRITE) begin
          t_idx = t_cnt - 8;
          if (t_idx < t_len) begin
            wmem[8'(int'(t_hdr[7]) + t_idx)] = bus.ospi_dq_o;
            t_cnt++;
          end else t_cnt = 0;
        end else begin
          t_idx = t_cnt - 10;
          if (t_cnt < 10) t_cnt++;
          else if (t_idx < t_len) begin
            bus.ospi_dq_i <= rmem[8'(int'(t_hdr[7]) + t_idx)];
            t_cnt++;
          end else t_cnt = 0;
        end
      end
    end
  end

  logic        c_write [2];
  logic [3:0]  c_size  [2];
  logic [23:0] c_len   [2];
  logic [31:0] c_addr  [2];
  logic [7:0]  tx_bytes [4];
  int s_slot, s_rx, s_ncs, dones, pauses, tx_taken;

  // Runs n queued commands (cmd_valid held between them), feeding tx_bytes with an optional stall.
  task automatic drive(input int n, input int stall_after, input int stall_n);
    int ci = 0, stall = 0, k = 0;
    logic stalled;
    dones = 0; pauses = 0; tx_taken = 0;
    @(posedge clk);
    s_slot = slot_q.size(); s_rx = rx_q.size(); s_ncs = ncs_tr.size();
    while (dones < n && k < 300) begin
      @(negedge clk);
      k++;
      if (bus.done) dones++;
      if (bus.busy && bus.ospi_ncs) pauses++;
      bus.cmd_valid = (ci < n);
      if (ci < n) begin
        bus.cmd_write = c_write[ci]; bus.cmd_size = c_size[ci];
        bus.cmd_len   = c_len[ci];   bus.cmd_addr = c_addr[ci];
      end
      stalled      = (stall > 0);
      bus.tx_valid = !stalled && (tx_taken < 4);
      bus.tx_data  = tx_bytes[(tx_taken < 4) ? tx_taken : 0];
      #1;
      if (bus.cmd_valid && bus.cmd_ready) ci++;
      if (stalled) stall--;
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_taken == stall_after) stall = stall_n;
        tx_taken++;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.tx_valid  = 1'b0;
    n_checks++;
    if (dones !== n) $display("FAIL done_count: got %0d, required %0d", dones, n);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_size = 4'd0;
    bus.cmd_len = 24'd0; bus.cmd_addr = 32'd0;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h5A;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ospi_ncs !== 1'b1) $display("FAIL rst_ncs: got %b, required 1", bus.ospi_ncs); else n_pass++;
    n_checks++; if (bus.ospi_dq_oe !== 1'b0) $display("FAIL rst_oe: got %b, required 0", bus.ospi_dq_oe); else n_pass++;
    n_checks++; if (bus.ospi_dq_o !== 8'h00) $display("FAIL rst_dq_o: got %h, required 00", bus.ospi_dq_o); else n_pass++;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b, required 0", bus.rx_valid); else n_pass++;
    n_checks++; if (bus.tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b, required 0", bus.tx_ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b, required 0", bus.done); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else n_pass++;
    reset_n = 1'b1;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b, required 1", bus.cmd_ready); else n_pass++;
  endtask

  task automatic test_write();
    logic [7:0] hdr [8] = '{8'hA0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h10};
    logic [8:0] got;
    c_write[0] = 1'b1; c_size[0] = 4'd0; c_len[0] = 24'd4; c_addr[0] = 32'h10;
    tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    drive(1, -1, 0);
    n_checks++; if (slot_q.size() - s_slot !== 13) $display("FAIL wr_ncs_low: got %0d, required 13", slot_q.size() - s_slot); else n_pass++;
    for (int i = 0; i < 13; i++) begin
      got = (s_slot + i < slot_q.size()) ? slot_q[s_slot + i] : 9'h1FF;
      n_checks++;
      if (i < 8 && got !== {1'b1, hdr[i]}) $display("FAIL wr_hdr[%0d]: got %h, required %h", i, got, {1'b1, hdr[i]});
      else if (i >= 8 && i < 12 && got !== {1'b1, tx_bytes[i-8]}) $display("FAIL wr_data[%0d]: got %h, required %h", i - 8, got, {1'b1, tx_bytes[i-8]});
      else if (i == 12 && got[8] !== 1'b0) $display("FAIL wr_tail_oe: got %b, required 0", got[8]);
      else n_pass++;
    end
    n_checks++; if (pauses !== 0) $display("FAIL wr_pauses: got %0d, required 0", pauses); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (wmem[8'h10 + i] !== tx_bytes[i]) $display("FAIL wr_mem[%0d]: got %h, required %h", i, wmem[8'h10 + i], tx_bytes[i]); else n_pass++;
    end
  endtask

  task automatic test_read();
    logic [7:0] hdr [8] = '{8'h20, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10};
    logic [7:0] exp_rx [3] = '{8'h11, 8'h22, 8'h33};
    logic [8:0] got;
    c_write[0] = 1'b0; c_size[0] = 4'd0; c_len[0] = 24'd3; c_addr[0] = 32'h10;
    tx_bytes = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
    drive(1, -1, 0);
    n_checks++; if (tx_taken !== 0) $display("FAIL rd_tx_ignored: got %0d taken, required 0", tx_taken); else n_pass++;
    n_checks++; if (slot_q.size() - s_slot !== 14) $display("FAIL rd_ncs_low: got %0d, required 14", slot_q.size() - s_slot); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      got = (s_slot + i < slot_q.size()) ? slot_q[s_slot + i] : 9'h1FF;
      n_checks++;
      if (i < 8 && got !== {1'b1, hdr[i]}) $display("FAIL rd_hdr[%0d]: got %h, required %h", i, got, {1'b1, hdr[i]});
      else if (i >= 8 && got[8] !== 1'b0) $display("FAIL rd_oe[%0d]: got %b, required 0", i, got[8]);
      else n_pass++;
    end
    n_checks++; if (rx_q.size() - s_rx !== 3) $display("FAIL rd_rx_count: got %0d, required 3", rx_q.size() - s_rx); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_rx + i >= rx_q.size() || rx_q[s_rx + i] !== exp_rx[i]) $display("FAIL rd_rx[%0d]: got %h, required %h", i, (s_rx + i < rx_q.size()) ? rx_q[s_rx + i] : 8'hXX, exp_rx[i]);
      else n_pass++;
    end
    n_checks++;
    if (rx_q.size() - s_rx < 3 || rx_cyc[s_rx + 2] - rx_cyc[s_rx] !== 2) $display("FAIL rd_rx_consecutive: got span %0d, required 2", (rx_q.size() - s_rx < 3) ? -1 : rx_cyc[s_rx + 2] - rx_cyc[s_rx]);
    else n_pass++;
  endtask

  task automatic test_underrun();
    logic [8:0] got;
    c_write[0] = 1'b1; c_size[0] = 4'd1; c_len[0] = 24'd4; c_addr[0] = 32'h20;
    tx_bytes = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    drive(1, 1, 2);
    n_checks++; if (pauses !== 2) $display("FAIL ur_pauses: got %0d, required 2", pauses); else n_pass++;
    n_checks++; if (slot_q.size() - s_slot !== 13) $display("FAIL ur_ncs_low: got %0d, required 13", slot_q.size() - s_slot); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (s_slot + 8 + i < slot_q.size()) ? slot_q[s_slot + 8 + i] : 9'h1FF;
      n_checks++; if (got !== {1'b1, tx_bytes[i]}) $display("FAIL ur_data[%0d]: got %h, required %h", i, got, {1'b1, tx_bytes[i]}); else n_pass++;
      n_checks++; if (wmem[8'h20 + i] !== tx_bytes[i]) $display("FAIL ur_mem[%0d]: got %h, required %h", i, wmem[8'h20 + i], tx_bytes[i]); else n_pass++;
    end
  endtask

  task automatic test_len0();
    logic [7:0] hdr [8] = '{8'h27, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30};
    logic [8:0] got;
    c_write[0] = 1'b0; c_size[0] = 4'd7; c_len[0] = 24'd0; c_addr[0] = 32'h30;
    drive(1, -1, 0);
    n_checks++; if (slot_q.size() - s_slot !== 11) $display("FAIL z_ncs_low: got %0d, required 11", slot_q.size() - s_slot); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      got = (s_slot + i < slot_q.size()) ? slot_q[s_slot + i] : 9'h1FF;
      n_checks++;
      if (i < 8 && got !== {1'b1, hdr[i]}) $display("FAIL z_hdr[%0d]: got %h, required %h", i, got, {1'b1, hdr[i]});
      else if (i >= 8 && got[8] !== 1'b0) $display("FAIL z_oe[%0d]: got %b, required 0", i, got[8]);
      else n_pass++;
    end
    n_checks++; if (rx_q.size() - s_rx !== 0) $display("FAIL z_rx_count: got %0d, required 0", rx_q.size() - s_rx); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_size = 4'd0;
    bus.cmd_len = 24'd4; bus.cmd_addr = 32'h00AB_0040; bus.tx_valid = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if ({bus.ospi_ncs, bus.ospi_dq_oe, bus.ospi_dq_o} !== {2'b01, 8'hAB}) $display("FAIL rm_slot5: got %b_%b_%h, required 0_1_ab", bus.ospi_ncs, bus.ospi_dq_oe, bus.ospi_dq_o); else n_pass++;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ospi_ncs !== 1'b1) $display("FAIL rm_ncs: got %b, required 1", bus.ospi_ncs); else n_pass++;
    n_checks++; if (bus.ospi_dq_oe !== 1'b0) $display("FAIL rm_oe: got %b, required 0", bus.ospi_dq_oe); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b, required 0", bus.busy); else n_pass++;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) $display("FAIL rm_no_done: got %b, required 0", saw_done); else n_pass++;
    c_write[0] = 1'b0; c_size[0] = 4'd0; c_len[0] = 24'd2; c_addr[0] = 32'h10;
    drive(1, -1, 0);
    n_checks++; if (slot_q.size() - s_slot !== 13) $display("FAIL rm_next_len: got %0d, required 13", slot_q.size() - s_slot); else n_pass++;
    n_checks++; if (s_slot >= slot_q.size() || slot_q[s_slot] !== 9'h120) $display("FAIL rm_next_byte0: got %h, required 120", (s_slot < slot_q.size()) ? slot_q[s_slot] : 9'h1FF); else n_pass++;
    n_checks++; if (s_slot + 7 >= slot_q.size() || slot_q[s_slot + 7] !== 9'h110) $display("FAIL rm_next_byte7: got %h, required 110", (s_slot + 7 < slot_q.size()) ? slot_q[s_slot + 7] : 9'h1FF); else n_pass++;
    n_checks++; if (rx_q.size() - s_rx !== 2 || rx_q[s_rx] !== 8'h11 || rx_q[s_rx + 1] !== 8'h22) $display("FAIL rm_next_rx: got %0d bytes, required 2 (11 22)", rx_q.size() - s_rx); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rx [5] = '{8'h11, 8'h22, 8'h99, 8'h88, 8'h77};
    int p, run1 = 0, gap = 0, run2 = 0;
    c_write[0] = 1'b0; c_size[0] = 4'd0; c_len[0] = 24'd2; c_addr[0] = 32'h10;
    c_write[1] = 1'b0; c_size[1] = 4'd0; c_len[1] = 24'd3; c_addr[1] = 32'h50;
    drive(2, -1, 0);
    p = s_ncs;
    while (p < ncs_tr.size() && ncs_tr[p] !== 1'b0) p++;
    while (p < ncs_tr.size() && ncs_tr[p] === 1'b0) begin run1++; p++; end
    while (p < ncs_tr.size() && ncs_tr[p] !== 1'b0) begin gap++; p++; end
    while (p < ncs_tr.size() && ncs_tr[p] === 1'b0) begin run2++; p++; end
    n_checks++; if (run1 !== 13) $display("FAIL b2b_frame1: got %0d, required 13", run1); else n_pass++;
    n_checks++; if (gap !== 1) $display("FAIL b2b_gap: got %0d, required 1", gap); else n_pass++;
    n_checks++; if (run2 !== 14) $display("FAIL b2b_frame2: got %0d, required 14", run2); else n_pass++;
    n_checks++; if (rx_q.size() - s_rx !== 5) $display("FAIL b2b_rx_count: got %0d, required 5", rx_q.size() - s_rx); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (s_rx + i >= rx_q.size() || rx_q[s_rx + i] !== exp_rx[i]) $display("FAIL b2b_rx[%0d]: got %h, required %h", i, (s_rx + i < rx_q.size()) ? rx_q[s_rx + i] : 8'hXX, exp_rx[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_underrun();
    test_len0();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
